// File: rtl/package_project_typedefs.sv
// Operation encodings shared by the integer execute units.
package package_project_typedefs;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } AluControl;

   // Ordered like the RV32M funct3 field.
   typedef enum logic [2:0] {
      MD_MUL    = 3'd0,
      MD_MULH   = 3'd1,
      MD_MULHSU = 3'd2,
      MD_MULHU  = 3'd3,
      MD_DIV    = 3'd4,
      MD_DIVU   = 3'd5,
      MD_REM    = 3'd6,
      MD_REMU   = 3'd7
   } MulDivControl;

endpackage

// File: rtl/muldiv_unit.sv
// Radix-2 iterative multiplier/divider with RV32M semantics at width XLEN.
//
// state  | meaning
// S_IDLE | ready for a new operation
// S_BUSY | one shift-add or restoring subtract-shift step per cycle
// S_DONE | result registered, done pulses for one cycle
module muldiv_unit
   import package_project_typedefs::*;
#(
   parameter int XLEN = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  MulDivControl      md_op,
   input  logic [XLEN-1:0]   in_a,
   input  logic [XLEN-1:0]   in_b,
   input  logic              start,
   input  logic              flush,
   output logic              ready,
   output logic              done,
   output logic [XLEN-1:0]   result,
   output logic              zero
);

   localparam int CW = $clog2(XLEN) + 1;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t              r_state, w_state_next;
   logic [CW-1:0]       r_cnt;
   logic [2*XLEN-1:0]   r_acc;
   logic [XLEN-1:0]     r_opd;
   MulDivControl        r_op;
   logic                r_neg;
   logic [XLEN-1:0]     r_result;

   logic                w_accept, w_is_div, w_a_signed, w_b_signed, w_sa, w_sb;
   logic                w_div_zero, w_ovf, w_special, w_neg_init;
   logic [XLEN-1:0]     w_mag_a, w_mag_b, w_special_res, w_final;
   logic [XLEN:0]       w_mul_sum, w_rem_sh, w_diff;
   logic                w_qbit;
   logic [2*XLEN-1:0]   w_acc_next, w_prod;
   logic [CW-1:0]       w_cnt_dec;

   assign w_accept  = (r_state == S_IDLE) && start && !flush;
   assign w_cnt_dec = r_cnt - 1'b1;

   always_comb begin
      w_is_div   = md_op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
      w_a_signed = md_op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
      w_b_signed = md_op inside {MD_MULH, MD_DIV, MD_REM};
      w_sa       = w_a_signed && in_a[XLEN-1];
      w_sb       = w_b_signed && in_b[XLEN-1];
      w_mag_a    = w_sa ? -in_a : in_a;
      w_mag_b    = w_sb ? -in_b : in_b;
      w_neg_init = (md_op == MD_REM) ? w_sa : (w_sa ^ w_sb);
      w_div_zero = w_is_div && (in_b == '0);
      w_ovf      = (md_op inside {MD_DIV, MD_REM}) && (in_a == {1'b1, {(XLEN-1){1'b0}}})
                   && (in_b == '1);
      w_special  = w_div_zero || w_ovf;
      w_special_res = in_a;
      if (w_div_zero && (md_op inside {MD_DIV, MD_DIVU}))
         w_special_res = '1;
      else if (w_ovf && (md_op == MD_REM))
         w_special_res = '0;
   end

   // Multiply keeps {partial product, multiplier}; divide keeps {remainder, quotient}.
   always_comb begin
      w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opd} : '0);
      w_rem_sh  = r_acc[2*XLEN-1:XLEN-1];
      w_diff    = w_rem_sh - {1'b0, r_opd};
      w_qbit    = w_rem_sh >= {1'b0, r_opd};
      if (r_op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU})
         w_acc_next = {(w_qbit ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0]),
                       r_acc[XLEN-2:0], w_qbit};
      else
         w_acc_next = {w_mul_sum, r_acc[XLEN-1:1]};
   end

   always_comb begin
      w_prod = r_neg ? -w_acc_next : w_acc_next;
      case (r_op)
         MD_MUL:                      w_final = w_prod[XLEN-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU: w_final = w_prod[2*XLEN-1:XLEN];
         MD_DIV, MD_DIVU:             w_final = r_neg ? -w_acc_next[XLEN-1:0]
                                                      : w_acc_next[XLEN-1:0];
         default:                     w_final = r_neg ? -w_acc_next[2*XLEN-1:XLEN]
                                                      : w_acc_next[2*XLEN-1:XLEN];
      endcase
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_state_next = w_special ? S_DONE : S_BUSY;
         S_BUSY: begin
            if (flush)                w_state_next = S_IDLE;
            else if (w_cnt_dec == '0) w_state_next = S_DONE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_opd    <= '0;
         r_op     <= MD_MUL;
         r_neg    <= 1'b0;
         r_result <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_op  <= md_op;
            r_neg <= w_neg_init;
            r_cnt <= w_special ? '0 : CW'(XLEN);
            r_acc <= {{XLEN{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
            r_opd <= w_is_div ? w_mag_b : w_mag_a;
            if (w_special)
               r_result <= w_special_res;
         end else if (r_state == S_BUSY) begin
            if (flush) begin
               r_cnt <= '0;
            end else begin
               r_acc <= w_acc_next;
               r_cnt <= w_cnt_dec;
               if (w_cnt_dec == '0)
                  r_result <= w_final;
            end
         end
      end
   end

   assign ready  = (r_state == S_IDLE);
   assign done   = (r_state == S_DONE);
   assign result = r_result;
   assign zero   = (r_result == '0);

endmodule
